dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and sequencer in front of the single-ported 8×16 data memory. It shares the memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA port) with round-robin priority. It drives the memory's address, read-enable, write-enable and write-data pins, and returns registered read data with a one-cycle latency. Out-of-range addresses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- DEPTH, 8, number of valid memory words; addresses ≥ DEPTH are errors
- LOCK_MAX, 4, maximum consecutive locked grants (used only with the lock feature)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  hold the grant for the next cycle (lock feature only)
- gnt0 / gnt1  out  1  combinational grant; the access occurs in this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse, response for the previous grant
- rdata0 / rdata1  out  DW  registered read data, valid with rvalid
- err0 / err1  out  1  registered, valid with rvalid; 1 = address out of range
- Address  out  AW  to the memory
- Mem_Read / Mem_Write  out  1  to the memory
- DM_WData  out  DW  to the memory
- DM_RData  in  DW  from the memory, combinational read

## Operation
- At most one grant per cycle. `gnt0` and `gnt1` are never both 1.
- Priority pointer `prio`:
  - With only one request, that requester is granted.
  - With both requesting, the requester named by `prio` wins.
  - After any grant, `prio` moves to the other requester.
- In-range access (`addr < DEPTH`):
  - The memory pins carry the granted requester's address and data.
  - `Mem_Read = !we` and `Mem_Write = we`.
  - The write commits at the end of the grant cycle.
  - For a read, `DM_RData` is captured into `rdataX` at the end of the grant cycle.
- Out-of-range access:
  - Grant is still given and `Mem_Read = Mem_Write = 0`.
  - The following cycle has `rvalidX = 1`, `errX = 1`, `rdataX = 0`.
- A write also produces `rvalidX` with `rdataX = 0`.
- No grant: all memory pins are 0.
- State machine `{IDLE, LOCK0, LOCK1}`:
  - IDLE → LOCKx when requester x is granted with `lockx = 1`.
  - LOCKx → IDLE when `lockx = 0`, when `reqx = 0`, or when `lock_cnt` reaches LOCK_MAX.
  - In LOCKx, requester x wins regardless of `prio`.
  - `lock_cnt` counts locked grants and clears in IDLE.

## Timing
- Grant is combinational in cycle N. The response (`rvalid`/`rdata`/`err`) is registered and visible in cycle N+1. Latency is 1 and throughput is 1 access per cycle.
- A request held low→high→held: the requester must keep `req`/`addr`/`we`/`wdata` stable until it sees `gnt`.
- Back-to-back requests from both requesters alternate: 0,1,0,1…
- Reset (asynchronous, mid-operation included):
  - Registered outputs clear: `rvalid*`, `err*`, `rdata*` = 0.
  - Internal state: `prio` = 0, state = IDLE, `lock_cnt` = 0.
  - While `RST_N = 0`, grants and memory pins are forced to 0, so no write can occur.
- A pending response in flight at reset is dropped.

## Configuration
- `DM_ARB_LOCK_EN` defined: the lock inputs, the FSM and `lock_cnt` are compiled in as described.
- `DM_ARB_LOCK_EN` undefined: `lock0`/`lock1` are ignored and the FSM is permanently IDLE. Arbitration is pure round-robin.

## Structure
- Shared package `dm_pkg`:
  - state enum `{IDLE, LOCK0, LOCK1}`
  - default `DEPTH`/`AW`/`DW` constants
  - the requester-index typedef
- One natural sub-module, `rr_pick2`: a combinational 2-way round-robin picker (`req[1:0]`, `prio`, `force_valid`, `force_idx` → `gnt[1:0]`).

## Test plan
- **Reset:** assert `RST_N = 0` mid-access with `req0 = 1`, `we0 = 1`.
  - Required: no memory write, all outputs 0.
  - After release, the first grant goes to requester 0.
- **Single write then read:** `req0` write addr 3 data 0x1234, then `req0` read addr 3.
  - Required: `gnt0` in each cycle.
  - The cycle after the read grant shows `rvalid0 = 1`, `rdata0 = 0x1234`, `err0 = 0`.
- **Contention:** `req0` and `req1` held high for 4 cycles, reading addresses 1 and 2.
  - Required: grants in order 0,1,0,1.
  - Each `rvalid` follows its grant by exactly 1 cycle.
- **Out-of-range:** `req1` read addr 8.
  - Required: `gnt1 = 1` and `Mem_Read = 0` in the grant cycle.
  - Next cycle `rvalid1 = 1`, `err1 = 1`, `rdata1 = 0`.
- **Lock (with `DM_ARB_LOCK_EN`, `LOCK_MAX = 4`):** `req1` with `lock1` held high while `req0` is also held high.
  - Required: `gnt1` for 4 consecutive cycles, then `gnt0`.
  - Without the macro, the same stimulus alternates grants.
- **Write-through-read collision:** `req0` write addr 5 = 0xBEEF in cycle N, `req1` read addr 5 in cycle N+1.
  - Required: `rdata1 = 0xBEEF` in N+2.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// State encoding, requester index and default geometry.
package dm_pkg;

  localparam int DM_AW    = 16;
  localparam int DM_DW    = 16;
  localparam int DM_DEPTH = 8;

  typedef logic idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  function automatic idx_t other(idx_t i);
    return ~i;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dm_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// A valid force wins when its requester asks.
module rr_pick2
  import dm_pkg::*;
(
  input  logic [1:0] req,
  input  idx_t       prio,
  input  logic       force_valid,
  input  idx_t       force_idx,
  output logic [1:0] gnt
);

  // force first, then prio on contention, else the lone requester
  always_comb begin
    gnt = '0;
    if (force_valid && req[force_idx]) begin
      gnt[force_idx] = 1'b1;
    end else if (req == 2'b11) begin
      gnt[prio] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the 8x16 data memory.
// Grant locking is compiled in with DM_ARB_LOCK_EN.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW       = DM_AW,
  parameter int DW       = DM_DW,
  parameter int DEPTH    = DM_DEPTH,
  parameter int LOCK_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  dm_arbiter_if.slave   p0,
  dm_arbiter_if.slave   p1,
  output logic [AW-1:0] Address,
  output logic          Mem_Read,
  output logic          Mem_Write,
  output logic [DW-1:0] DM_WData,
  input  logic [DW-1:0] DM_RData
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  idx_t          prio;
  idx_t          sel;
  logic          any;
  logic          force_valid;
  idx_t          force_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          in_rng;
  logic [1:0]    rvalid_q;
  logic [1:0]    err_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  assign req = {p1.req, p0.req} & {2{RST_N}};

  rr_pick2 u_pick (
    .req         (req),
    .prio        (prio),
    .force_valid (force_valid),
    .force_idx   (force_idx),
    .gnt         (gnt)
  );

  assign any       = |gnt;
  assign sel       = gnt[1];
  assign sel_addr  = sel ? p1.addr  : p0.addr;
  assign sel_wdata = sel ? p1.wdata : p0.wdata;
  assign sel_we    = sel ? p1.we    : p0.we;
  assign in_rng    = sel_addr < AW'(DEPTH);

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.err    = err_q[0];
  assign p1.err    = err_q[1];
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

  // memory pins carry the winner only when in range
  always_comb begin
    Address   = '0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    DM_WData  = '0;
    if (any && in_rng) begin
      Address   = sel_addr;
      Mem_Read  = !sel_we;
      Mem_Write = sel_we;
      DM_WData  = sel_wdata;
    end
  end

  // one-cycle registered response
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & {2{!in_rng}};
      rdata0_q <= (gnt[0] && Mem_Read) ? DM_RData : '0;
      rdata1_q <= (gnt[1] && Mem_Read) ? DM_RData : '0;
    end
  end

  // priority flips to the loser after each grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prio <= 1'b0;
    end else if (any) begin
      prio <= other(sel);
    end
  end

`ifdef DM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state;
  arb_state_e    state_d;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = lock_cnt + CW'(1);

  // lock state and count register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_d;
      lock_cnt <= cnt_d;
    end
  end

  // owner of the lock is forced through the picker
  always_comb begin
    force_valid = 1'b0;
    force_idx   = 1'b0;
    unique case (state)
      LOCK0: begin
        force_valid = 1'b1;
        force_idx   = 1'b0;
      end
      LOCK1: begin
        force_valid = 1'b1;
        force_idx   = 1'b1;
      end
      default: ;
    endcase
  end

  // enter on a locked grant, leave on release or budget
  always_comb begin
    state_d = state;
    cnt_d   = lock_cnt;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (LOCK_MAX > 1) begin
          if (gnt[0] && p0.lock) begin
            state_d = LOCK0;
            cnt_d   = CW'(1);
          end else if (gnt[1] && p1.lock) begin
            state_d = LOCK1;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK0: begin
        if (!p0.req || !p0.lock ||
            cnt_inc >= CW'(LOCK_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCK1: begin
        if (!p1.req || !p1.lock ||
            cnt_inc >= CW'(LOCK_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic unused_lock;

  assign unused_lock = p0.lock ^ p1.lock;
  assign force_valid = 1'b0;
  assign force_idx   = 1'b0;
`endif

endmodule
